// File: rtl/rwt_mailbox_pkg.sv
// Shared constants for the rwt_up_mailbox register block: word addresses,
// the VERSION value and the CONTROL/STATUS bit positions.
package rwt_mailbox_pkg;

    localparam logic [8:0] ADDR_VERSION = 9'h000;
    localparam logic [8:0] ADDR_ID      = 9'h001;
    localparam logic [8:0] ADDR_SCRATCH = 9'h002;
    localparam logic [8:0] ADDR_CONTROL = 9'h003;
    localparam logic [8:0] ADDR_STATUS  = 9'h004;
    localparam logic [8:0] ADDR_LEVEL   = 9'h005;
    localparam logic [8:0] ADDR_TX_DATA = 9'h010;
    localparam logic [8:0] ADDR_RX_DATA = 9'h011;

    localparam logic [31:0] VERSION_VALUE = 32'h0001_0000;

    // CONTROL bits
    localparam int CTRL_TX_FLUSH = 0;
    localparam int CTRL_RX_FLUSH = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // STATUS bits
    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_TX_OVF   = 8;
    localparam int STAT_RX_UNF   = 9;

endpackage

// File: rtl/rwt_up_mailbox_fifo.sv
// rwt_sync_fifo: single-clock first-word-fall-through FIFO of 32-bit words.
// Pointers carry an extra wrap bit so full and empty are told apart without
// a separate counter. Push when full and pop when empty are ignored; flush
// wins over a same-cycle push or pop.
module rwt_sync_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [31:0]         mem_r [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_r;
    logic [DEPTH_LOG2:0] rd_ptr_r;
    logic                push_ok_s;
    logic                pop_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                       (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];

    // Pointer update: flush resets both pointers, otherwise advance on accepted push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
            rd_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
            rd_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/rwt_up_mailbox.sv
// rwt_up_mailbox: up_* register-bus mailbox with a TX FIFO streaming into
// fabric and an RX FIFO collecting from fabric, plus ID/scratch/status
// registers. The level/error interrupt and CONTROL[2] exist only when
// RWT_MAILBOX_IRQ_EN is defined; otherwise irq is tied low.
module rwt_up_mailbox
    import rwt_mailbox_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [31:0] ID         = 32'h0
) (
    input  logic        up_clk,
    input  logic        up_rstn,
    input  logic        up_wreq,
    input  logic [8:0]  up_waddr,
    input  logic [31:0] up_wdata,
    output logic        up_wack,
    input  logic        up_rreq,
    input  logic [8:0]  up_raddr,
    output logic [31:0] up_rdata,
    output logic        up_rack,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        irq
);

    logic                tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [DEPTH_LOG2:0] tx_level_s, rx_level_s;
    logic [31:0]         tx_head_s, rx_head_s;
    logic                tx_push_s, rx_pop_s, rx_push_s;
    logic                wr_ctrl_s, wr_status_s, wr_scratch_s;
    logic                tx_flush_s, rx_flush_s;
    logic                irq_en_s, irq_next_s;
    logic [31:0]         status_s, level_s, rd_value_s;

    logic                s_ready_en_r;
    logic                tx_ovf_r, rx_unf_r;
    logic [31:0]         scratch_r;
    logic                wack_r, rack_r, irq_r;
    logic [31:0]         rdata_r;

    // Request decode; side effects take place on the request cycle's edge.
    assign wr_ctrl_s    = up_wreq && (up_waddr == ADDR_CONTROL);
    assign wr_status_s  = up_wreq && (up_waddr == ADDR_STATUS);
    assign wr_scratch_s = up_wreq && (up_waddr == ADDR_SCRATCH);
    assign tx_push_s    = up_wreq && (up_waddr == ADDR_TX_DATA);
    assign rx_pop_s     = up_rreq && (up_raddr == ADDR_RX_DATA);
    assign tx_flush_s   = wr_ctrl_s && up_wdata[CTRL_TX_FLUSH];
    assign rx_flush_s   = wr_ctrl_s && up_wdata[CTRL_RX_FLUSH];
    assign rx_push_s    = s_valid && s_ready;

    rwt_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (up_clk),
        .rst_n (up_rstn),
        .push  (tx_push_s),
        .pop   (m_ready),
        .flush (tx_flush_s),
        .wdata (up_wdata),
        .rdata (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .level (tx_level_s)
    );

    rwt_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (up_clk),
        .rst_n (up_rstn),
        .push  (rx_push_s),
        .pop   (rx_pop_s),
        .flush (rx_flush_s),
        .wdata (s_data),
        .rdata (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .level (rx_level_s)
    );

    // Fabric side: all terms come from flops; m_data is forced to 0 when empty.
    assign m_valid = ~tx_empty_s;
    assign m_data  = tx_empty_s ? 32'h0 : tx_head_s;
    assign s_ready = s_ready_en_r & ~rx_full_s;

`ifdef RWT_MAILBOX_IRQ_EN
    logic irq_en_r;

    // Interrupt enable bit in CONTROL.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            irq_en_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            irq_en_r <= up_wdata[CTRL_IRQ_EN];
        end
    end

    assign irq_en_s = irq_en_r;
`else
    assign irq_en_s = 1'b0;
`endif

    assign irq_next_s = irq_en_s & (~rx_empty_s | tx_ovf_r | rx_unf_r);

    // s_ready stays low during reset and rises the first edge after release.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            s_ready_en_r <= 1'b0;
        end else begin
            s_ready_en_r <= 1'b1;
        end
    end

    // Sticky error flags: a new event in the same cycle beats a W1C clear.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            tx_ovf_r <= 1'b0;
            rx_unf_r <= 1'b0;
        end else begin
            tx_ovf_r <= (tx_ovf_r & ~(wr_status_s & up_wdata[STAT_TX_OVF])) |
                        (tx_push_s & tx_full_s);
            rx_unf_r <= (rx_unf_r & ~(wr_status_s & up_wdata[STAT_RX_UNF])) |
                        (rx_pop_s & rx_empty_s);
        end
    end

    // Scratch register.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            scratch_r <= 32'h0;
        end else if (wr_scratch_s) begin
            scratch_r <= up_wdata;
        end
    end

    // Assemble STATUS and LEVEL words from live FIFO state.
    always_comb begin
        status_s                = 32'h0;
        status_s[STAT_TX_FULL]  = tx_full_s;
        status_s[STAT_TX_EMPTY] = tx_empty_s;
        status_s[STAT_RX_FULL]  = rx_full_s;
        status_s[STAT_RX_EMPTY] = rx_empty_s;
        status_s[STAT_TX_OVF]   = tx_ovf_r;
        status_s[STAT_RX_UNF]   = rx_unf_r;
        level_s = {{(15-DEPTH_LOG2){1'b0}}, rx_level_s,
                   {(15-DEPTH_LOG2){1'b0}}, tx_level_s};
    end

    // Read data mux; write-only and unmapped addresses read as 0.
    always_comb begin
        rd_value_s = 32'h0;
        case (up_raddr)
            ADDR_VERSION: rd_value_s = VERSION_VALUE;
            ADDR_ID:      rd_value_s = ID;
            ADDR_SCRATCH: rd_value_s = scratch_r;
            ADDR_CONTROL: rd_value_s = {29'h0, irq_en_s, 2'b00};
            ADDR_STATUS:  rd_value_s = status_s;
            ADDR_LEVEL:   rd_value_s = level_s;
            ADDR_RX_DATA: rd_value_s = rx_empty_s ? 32'h0 : rx_head_s;
            default:      rd_value_s = 32'h0;
        endcase
    end

    // Bus acks, registered read data (zero outside rack) and interrupt.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            wack_r  <= 1'b0;
            rack_r  <= 1'b0;
            rdata_r <= 32'h0;
            irq_r   <= 1'b0;
        end else begin
            wack_r  <= up_wreq;
            rack_r  <= up_rreq;
            rdata_r <= up_rreq ? rd_value_s : 32'h0;
            irq_r   <= irq_next_s;
        end
    end

    assign up_wack  = wack_r;
    assign up_rack  = rack_r;
    assign up_rdata = rdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_rwt_up_mailbox.sv
// Self-checking bench for rwt_up_mailbox: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rwt_up_mailbox;

    localparam int          DL     = 4;
    localparam int          DEPTH  = 1 << DL;
    localparam logic [31:0] TB_ID  = 32'hC0FF_EE01;
`ifdef RWT_MAILBOX_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        up_clk = 1'b0;
    logic        up_rstn;
    logic        up_wreq, up_rreq;
    logic [8:0]  up_waddr, up_raddr;
    logic [31:0] up_wdata, up_rdata;
    logic        up_wack, up_rack;
    logic [31:0] m_data, s_data;
    logic        m_valid, m_ready, s_valid, s_ready, irq;

    rwt_up_mailbox #(.DEPTH_LOG2(DL), .ID(TB_ID)) dut (
        .up_clk(up_clk), .up_rstn(up_rstn),
        .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
        .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .irq(irq)
    );

    always #5 up_clk = ~up_clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] m_scratch;
    bit          m_irq_en, m_ovf, m_unf, m_rdy_en;
    bit          e_wack, e_rack, e_irq, e_sready;
    logic [31:0] e_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        tx_q.delete(); rx_q.delete();
        m_scratch = 32'h0; m_irq_en = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_rdy_en = 1'b0; e_wack = 1'b0; e_rack = 1'b0; e_irq = 1'b0;
        e_sready = 1'b0; e_rdata = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [8:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            9'h000: v = 32'h0001_0000;
            9'h001: v = TB_ID;
            9'h002: v = m_scratch;
            9'h003: v = {29'h0, m_irq_en, 2'b00};
            9'h004: v = {22'h0, m_unf, m_ovf, 4'h0, rx_q.size() == 0, rx_q.size() == DEPTH,
                         tx_q.size() == 0, tx_q.size() == DEPTH};
            9'h005: v = {16'(rx_q.size()), 16'(tx_q.size())};
            9'h011: v = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic compare_all();
        chk("wack", {31'h0, up_wack}, {31'h0, e_wack});
        chk("rack", {31'h0, up_rack}, {31'h0, e_rack});
        chk("rdata", up_rdata, e_rdata);
        chk("m_valid", {31'h0, m_valid}, {31'h0, tx_q.size() > 0});
        chk("m_data", m_data, (tx_q.size() > 0) ? tx_q[0] : 32'h0);
        chk("s_ready", {31'h0, s_ready}, {31'h0, e_sready});
        chk("irq", {31'h0, irq}, {31'h0, e_irq});
    endtask

    // One clock: model the edge from the inputs in force, then compare at negedge.
    task automatic step();
        int pre_tx, pre_rx;
        bit pre_sready, set_ovf, set_unf, ctrl;
        @(posedge up_clk);
        if (!up_rstn) begin
            model_reset();
        end else begin
            pre_tx = tx_q.size();
            pre_rx = rx_q.size();
            pre_sready = e_sready;
            e_irq   = IRQ_ON & m_irq_en & ((pre_rx != 0) | m_ovf | m_unf);
            e_rdata = up_rreq ? model_read(up_raddr) : 32'h0;
            e_wack  = up_wreq;
            e_rack  = up_rreq;
            ctrl    = up_wreq && (up_waddr == 9'h003);
            set_ovf = 1'b0;
            set_unf = 1'b0;
            if (m_ready && pre_tx > 0) void'(tx_q.pop_front());
            if (up_wreq && up_waddr == 9'h010) begin
                if (pre_tx < DEPTH) tx_q.push_back(up_wdata);
                else set_ovf = 1'b1;
            end
            if (ctrl && up_wdata[0]) tx_q.delete();
            if (up_rreq && up_raddr == 9'h011) begin
                if (pre_rx > 0) void'(rx_q.pop_front());
                else set_unf = 1'b1;
            end
            if (s_valid && pre_sready) rx_q.push_back(s_data);
            if (ctrl && up_wdata[1]) rx_q.delete();
            if (up_wreq && up_waddr == 9'h002) m_scratch = up_wdata;
            if (ctrl) m_irq_en = IRQ_ON & up_wdata[2];
            if (up_wreq && up_waddr == 9'h004) begin
                if (up_wdata[8]) m_ovf = 1'b0;
                if (up_wdata[9]) m_unf = 1'b0;
            end
            if (set_ovf) m_ovf = 1'b1;
            if (set_unf) m_unf = 1'b1;
            m_rdy_en = 1'b1;
            e_sready = rx_q.size() < DEPTH;
        end
        @(negedge up_clk);
        compare_all();
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] d);
        up_wreq = 1'b1; up_waddr = a; up_wdata = d;
        step();
        up_wreq = 1'b0;
    endtask

    task automatic do_read(input logic [8:0] a, output logic [31:0] d);
        up_rreq = 1'b1; up_raddr = a;
        step();
        chk("rack_lit", {31'h0, up_rack}, 32'h1);
        d = up_rdata;
        up_rreq = 1'b0;
    endtask

    logic [8:0] addr_tab [11] = '{9'h000, 9'h001, 9'h002, 9'h003, 9'h004, 9'h005,
                                  9'h010, 9'h010, 9'h011, 9'h006, 9'h1FF};

    initial begin
        logic [31:0] d;
        up_rstn = 1'b0; up_wreq = 1'b0; up_rreq = 1'b0; up_waddr = 9'h0; up_raddr = 9'h0;
        up_wdata = 32'h0; m_ready = 1'b0; s_valid = 1'b0; s_data = 32'h0;
        model_reset();
        step(); step();
        chk("reset_s_ready", {31'h0, s_ready}, 32'h0);
        up_rstn = 1'b1;
        step();
        chk("post_reset_s_ready", {31'h0, s_ready}, 32'h1);

        // Identification and status after reset
        do_read(9'h000, d); chk("version", d, 32'h0001_0000);
        do_read(9'h001, d); chk("id", d, TB_ID);
        do_read(9'h004, d); chk("status_reset", d, 32'h0000_000A);
        step();

        // TX streaming in order
        do_write(9'h010, 32'hA5A5_0001);
        do_write(9'h010, 32'hA5A5_0002);
        do_write(9'h010, 32'hA5A5_0003);
        do_read(9'h005, d); chk("tx_level3", {16'h0, d[15:0]}, 32'd3);
        m_ready = 1'b1;
        chk("m_data1", m_data, 32'hA5A5_0001);
        step(); chk("m_data2", m_data, 32'hA5A5_0002);
        step(); chk("m_data3", m_data, 32'hA5A5_0003);
        step(); chk("m_valid_drained", {31'h0, m_valid}, 32'h0);
        m_ready = 1'b0;

        // TX overflow and W1C
        for (int i = 0; i < 17; i++) do_write(9'h010, 32'h100 + i);
        do_read(9'h004, d); chk("tx_ovf_set", {30'h0, d[8], d[0]}, 32'h3);
        do_write(9'h004, 32'h100);
        do_read(9'h004, d); chk("tx_ovf_clr", {31'h0, d[8]}, 32'h0);
        do_write(9'h003, 32'h1);
        chk("tx_flushed", {31'h0, m_valid}, 32'h0);

        // RX pop, underflow, same-cycle push retained
        s_valid = 1'b1; s_data = 32'h1234;
        step();
        s_valid = 1'b0;
        do_read(9'h011, d); chk("rx_word", d, 32'h1234);
        s_valid = 1'b1; s_data = 32'h5555;
        do_read(9'h011, d); chk("rx_empty_read", d, 32'h0);
        s_valid = 1'b0;
        do_read(9'h004, d); chk("rx_unf_set", {31'h0, d[9]}, 32'h1);
        do_read(9'h005, d); chk("rx_level1", {16'h0, d[31:16]}, 32'd1);
        do_read(9'h011, d); chk("rx_retained", d, 32'h5555);
        do_write(9'h004, 32'h200);

        // RX fill then flush
        s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = 32'hD000_0000 + i;
            step();
        end
        s_valid = 1'b0;
        chk("rx_full_s_ready", {31'h0, s_ready}, 32'h0);
        do_write(9'h003, 32'h2);
        chk("rx_flush_s_ready", {31'h0, s_ready}, 32'h1);
        do_read(9'h004, d); chk("rx_flush_empty", {31'h0, d[3]}, 32'h1);

        // Interrupt
        do_write(9'h003, 32'h4);
        s_valid = 1'b1; s_data = 32'hBEEF;
        step();
        s_valid = 1'b0;
        chk("irq_lag", {31'h0, irq}, 32'h0);
        step();
        chk("irq_on", {31'h0, irq}, {31'h0, IRQ_ON});
        do_read(9'h011, d);
        chk("irq_hold", {31'h0, irq}, {31'h0, IRQ_ON});
        step();
        chk("irq_off", {31'h0, irq}, 32'h0);

        // Randomized traffic, model compared every cycle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                up_wreq = 1'b0; up_rreq = 1'b0;
                up_rstn = 1'b0;
                step(); step();
                up_rstn = 1'b1;
            end
            up_wreq  = ($urandom % 3) == 0;
            up_waddr = addr_tab[$urandom_range(0, 10)];
            up_wdata = $urandom;
            if (up_waddr == 9'h003 && ($urandom % 4) != 0) up_wdata[1:0] = 2'b00;
            up_rreq  = ($urandom % 3) == 0;
            up_raddr = addr_tab[$urandom_range(0, 10)];
            if ((i % 400) < 200) begin
                m_ready = ($urandom % 8) == 0;
                s_valid = ($urandom % 4) != 0;
            end else begin
                m_ready = ($urandom % 2) == 0;
                s_valid = ($urandom % 4) == 0;
            end
            s_data = $urandom;
            step();
        end
        up_wreq = 1'b0; up_rreq = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rwt_up_mailbox.md
# rwt_up_mailbox

Register-mapped mailbox slave on the `up_*` register bus; one instance occupies one block slot of the common register decoder (`up_wreq[i]`/`up_rreq[i]` in, `up_wack[i]`/`up_rack[i]`/`up_rdata[32*i +: 32]` out). It gives the processor a TX FIFO that streams words into fabric (valid/ready) and an RX FIFO that collects words from fabric. It also provides ID/scratch/status registers and a level/error interrupt.

## Interface
- `DEPTH_LOG2`, 4: each FIFO holds 2^DEPTH_LOG2 32-bit words (legal 2..10).
- `ID`, 32'h0: value returned by the ID register.
- `up_clk`  in  1  register/fabric clock.
- `up_rstn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `up_wreq`  in  1  write request, one-cycle pulse.
- `up_waddr`  in  9  word address.
- `up_wdata`  in  32  write data.
- `up_wack`  out  1  write acknowledge.
- `up_rreq`  in  1  read request, one-cycle pulse.
- `up_raddr`  in  9  word address.
- `up_rdata`  out  32  read data, valid with `up_rack`.
- `up_rack`  out  1  read acknowledge.
- `m_data`  out  32  TX FIFO head.
- `m_valid`  out  1  TX FIFO not empty.
- `m_ready`  in  1  fabric accepts `m_data`.
- `s_data`  in  32  word into RX FIFO.
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  RX FIFO not full.
- `irq`  out  1  level interrupt, registered.

## Operation
- Register map, word addresses:
  - 0x000 VERSION, RO, 32'h0001_0000.
  - 0x001 ID, RO.
  - 0x002 SCRATCH, RW, reset 0.
  - 0x003 CONTROL: [0] tx_flush (W, self-clearing, reads 0); [1] rx_flush (same); [2] irq_en (RW, reset 0).
  - 0x004 STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty; [8] tx_overflow and [9] rx_underflow are sticky, write-1-to-clear.
  - 0x005 LEVEL: [15:0] tx level, [31:16] rx level, zero-extended from DEPTH_LOG2+1 bits.
  - 0x010 TX_DATA, WO: push.
  - 0x011 RX_DATA, RO: pop.
- Unmapped or WO reads return 0 and are still acked. Unmapped or RO writes are acked and ignored.
- TX push when full: word dropped, tx_overflow set. Full is sampled before the cycle, so a same-cycle `m_ready` pop does not make room.
- TX pop on `m_valid && m_ready`. `m_data` is the FIFO head (first-word-fall-through).
- RX push on `s_valid && s_ready`.
- RX_DATA read when empty returns 0 and sets rx_underflow. A same-cycle `s_valid` push is still stored.
- Flush empties the addressed FIFO in the cycle after the CONTROL write. Flush beats any same-cycle push or pop on that FIFO. Sticky flags are unaffected.
- Next-state of `irq` = irq_en & (!rx_empty | tx_overflow | rx_underflow).
- Reset values:
  - All outputs 0.
  - FIFOs empty, so `s_ready`=1 one cycle after reset release.
  - Sticky flags 0, SCRATCH 0, irq_en 0.
- Reset mid-transfer discards FIFO contents and any pending ack.

## Timing
- `up_wack` is high exactly one cycle after `up_wreq`; `up_rack` likewise after `up_rreq`. Both are low otherwise.
- `up_rdata` is registered, valid only while `up_rack`=1, and 0 otherwise.
- Side effects (push, pop, flag set/clear) commit on the request cycle's clock edge.
- TX_DATA write at cycle N: `m_valid`=1 and LEVEL shows the new count from N+1.
- RX pop: the next RX_DATA read returns the following word. Back-to-back reads on consecutive cycles are legal.
- `s_ready` and `m_valid` are registered from the pointer state. No combinational path from `m_ready`/`s_valid` to any output.
- `irq` changes one cycle after the condition changes.

## Configuration
- `RWT_MAILBOX_IRQ_EN` defined: CONTROL[2] and `irq` behave as above.
- Not defined:
  - `irq` tied 0.
  - CONTROL[2] reads 0 and ignores writes.
  - The port list is unchanged.

## Structure
- Package `rwt_mailbox_pkg`: register address constants, VERSION value, CONTROL/STATUS bit indices.
- Sub-module `rwt_sync_fifo`, instantiated twice (TX, RX).
  - Parameter: DEPTH_LOG2.
  - Ports: push, pop, flush, data in/out, full, empty, level.
  - Pointers are DEPTH_LOG2+1 bits with a wrap bit.
- Top level holds register decode, ack/rdata registers, sticky flags, irq.

## Test plan
- Reset, then read 0x000/0x001/0x004: 32'h0001_0000, ID, 32'h0000_000A; each `up_rack` exactly 1 cycle after `up_rreq`.
- Write 0xA5A5_0001..0xA5A5_0003 to 0x010 with `m_ready`=0 → LEVEL[15:0]=3. Raise `m_ready` → `m_data` 0xA5A5_0001, _0002, _0003 on consecutive cycles, then `m_valid`=0.
- DEPTH_LOG2=4, `m_ready`=0, 17 pushes → the 17th is dropped and STATUS[8]=1. Write 0x100 to 0x004 → STATUS[8]=0.
- Push 0x1234 on `s_data`, read 0x011 → 0x1234. Read again → 0 and STATUS[9]=1. Same-cycle `s_valid` push during the empty read is retained (LEVEL[31:16]=1).
- 16 RX words (`s_ready` drops to 0), then write 0x2 to 0x003 → rx_empty=1 and `s_ready`=1 next cycle.
- With macro: irq_en=1 and one RX word → `irq`=1 one cycle later; pop → `irq`=0. Without macro → `irq` stays 0.
